nonce_queue: RTL and testbench

NONCE_QUEUE -- requirements
Module: nonce_queue

---
 rtl/nonce_pkg.sv | 8 +
 rtl/nonce_fifo.sv | 79 +++++++
 rtl/nonce_queue.sv | 117 +++++++++++
 tb/tb_nonce_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_pkg.sv
// Shared constants for the nonce queue: byte width and default nonce/FIFO sizing.
package nonce_pkg;

    localparam int BYTE_W          = 8;
    localparam int NONCE_W_DEFAULT = 64;
    localparam int DEPTH_DEFAULT   = 4;

endpackage : nonce_pkg

// File: rtl/nonce_fifo.sv
// Synchronous FIFO holding assembled nonces; pointers wrap naturally, full/empty come from count.
module nonce_fifo
    import nonce_pkg::*;
#(
    parameter int WIDTH = NONCE_W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       push_ok_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign push_ok_o = push_ok;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
    always_comb begin
        pop_ok   = pop_i && !empty_o && !clear_i;
        push_ok  = push_i && !clear_i && (!full_o || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; the head is only meaningful while non-empty.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule : nonce_fifo

// File: rtl/nonce_queue.sv
// Assembles serial bytes little-endian into nonces and queues them for a consumer.
// Optional macro NONCE_QUEUE_DROP_CNT_EN adds a saturating dropped-nonce counter (drop_cnt_o).
module nonce_queue
    import nonce_pkg::*;
#(
    parameter int NONCE_W = NONCE_W_DEFAULT,
    parameter int DEPTH   = DEPTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [BYTE_W-1:0]        byte_i,
    input  logic                     byte_valid_i,
    input  logic                     flush_i,
    output logic [NONCE_W-1:0]       nonce_o,
    output logic                     nonce_valid_o,
    input  logic                     nonce_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
`ifdef NONCE_QUEUE_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt_o
`endif
);

    localparam int NBYTES = NONCE_W / BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [NONCE_W-1:0] asm_q, asm_d;
    logic               overflow_q, overflow_d;
    logic               last_byte;
    logic               push_req;
    logic               pop_req;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push_ok;

    assign last_byte = (byte_idx_q == IDX_W'(NBYTES - 1));
    assign push_req  = byte_valid_i && !flush_i && last_byte;
    assign pop_req   = nonce_valid_o && nonce_ready_i;
    assign drop      = push_req && !fifo_push_ok;

    // The last byte is merged combinationally so the pushed word already contains it.
    always_comb begin
        asm_d      = asm_q;
        byte_idx_d = byte_idx_q;
        overflow_d = overflow_q | drop;
        if (flush_i) begin
            byte_idx_d = '0;
            overflow_d = 1'b0;
        end else if (byte_valid_i) begin
            asm_d[int'(byte_idx_q)*BYTE_W +: BYTE_W] = byte_i;
            byte_idx_d = last_byte ? '0 : byte_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_idx_q <= '0;
            asm_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            overflow_q <= overflow_d;
        end
    end

    nonce_fifo #(
        .WIDTH (NONCE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (flush_i),
        .push_i    (push_req),
        .pop_i     (pop_req),
        .wdata_i   (asm_d),
        .rdata_o   (nonce_o),
        .count_o   (count_o),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .push_ok_o (fifo_push_ok)
    );

    assign nonce_valid_o = !fifo_empty;
    assign overflow_o    = overflow_q;

`ifdef NONCE_QUEUE_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (flush_i) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

    // fifo_full is observed only through fifo_push_ok; keep it visible for debug.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule : nonce_queue

// File: tb/tb_nonce_queue.sv
// Directed self-checking bench for nonce_queue at NONCE_W=64, DEPTH=4.
module tb_nonce_queue;

    logic        clk_i;
    logic        rst_ni;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        flush_i;
    logic [63:0] nonce_o;
    logic        nonce_valid_o;
    logic        nonce_ready_i;
    logic [2:0]  count_o;
    logic        overflow_o;
`ifdef NONCE_QUEUE_DROP_CNT_EN
    logic [15:0] drop_cnt_o;
`endif

    int compared;
    int mismatched;

    nonce_queue #(.NONCE_W(64), .DEPTH(4)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .byte_i        (byte_i),
        .byte_valid_i  (byte_valid_i),
        .flush_i       (flush_i),
        .nonce_o       (nonce_o),
        .nonce_valid_o (nonce_valid_o),
        .nonce_ready_i (nonce_ready_i),
        .count_o       (count_o),
        .overflow_o    (overflow_o)
`ifdef NONCE_QUEUE_DROP_CNT_EN
        ,
        .drop_cnt_o    (drop_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_i       = b;
        byte_valid_i = 1'b1;
        tick();
        byte_valid_i = 1'b0;
    endtask

    // Nonce n is built from bytes {n,1}..{n,8}, so byte k lands in bits [8k-1:8k-8].
    function automatic logic [63:0] make_nonce(input logic [3:0] n);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = {n, 4'(i + 1)};
        return v;
    endfunction

    task automatic send_nonce(input logic [3:0] n);
        for (int i = 1; i <= 8; i++) send_byte({n, 4'(i)});
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        compared++;
        if (count_o !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", count_o); end
        compared++;
        if (nonce_valid_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", nonce_valid_o); end
        compared++;
        if (overflow_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_assembly();
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        check64("asm_nonce", nonce_o, 64'h0807060504030201);
        compared++;
        if (nonce_valid_o !== 1'b1) begin mismatched++; $display("[TB] FAIL asm_valid: got %b expected 1", nonce_valid_o); end
        compared++;
        if (count_o !== 3'd1) begin mismatched++; $display("[TB] FAIL asm_count: got %0d expected 1", count_o); end
        nonce_ready_i = 1'b1;
        tick();
        nonce_ready_i = 1'b0;
        compared++;
        if (nonce_valid_o !== 1'b0) begin mismatched++; $display("[TB] FAIL asm_pop_valid: got %b expected 0", nonce_valid_o); end
    endtask

    task automatic test_overflow();
        for (int n = 1; n <= 5; n++) send_nonce(4'(n));
        compared++;
        if (count_o !== 3'd4) begin mismatched++; $display("[TB] FAIL ovf_count: got %0d expected 4", count_o); end
        compared++;
        if (overflow_o !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow_o); end
        check64("ovf_head", nonce_o, make_nonce(4'd1));
`ifdef NONCE_QUEUE_DROP_CNT_EN
        compared++;
        if (drop_cnt_o !== 16'd1) begin mismatched++; $display("[TB] FAIL ovf_drop_cnt: got %0d expected 1", drop_cnt_o); end
`endif
        for (int n = 1; n <= 4; n++) begin
            check64($sformatf("ovf_order%0d", n), nonce_o, make_nonce(4'(n)));
            nonce_ready_i = 1'b1;
            tick();
            nonce_ready_i = 1'b0;
        end
        compared++;
        if (count_o !== 3'd0) begin mismatched++; $display("[TB] FAIL ovf_drain_count: got %0d expected 0", count_o); end
        compared++;
        if (overflow_o !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow_o); end
        do_flush();
        compared++;
        if (overflow_o !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_flush_clear: got %b expected 0", overflow_o); end
`ifdef NONCE_QUEUE_DROP_CNT_EN
        compared++;
        if (drop_cnt_o !== 16'd0) begin mismatched++; $display("[TB] FAIL ovf_drop_clear: got %0d expected 0", drop_cnt_o); end
`endif
    endtask

    task automatic test_full_push_pop();
        for (int n = 1; n <= 4; n++) send_nonce(4'(n));
        for (int i = 1; i <= 7; i++) send_byte({4'd5, 4'(i)});
        nonce_ready_i = 1'b1;
        send_byte(8'h58);
        nonce_ready_i = 1'b0;
        compared++;
        if (count_o !== 3'd4) begin mismatched++; $display("[TB] FAIL full_pp_count: got %0d expected 4", count_o); end
        compared++;
        if (overflow_o !== 1'b0) begin mismatched++; $display("[TB] FAIL full_pp_overflow: got %b expected 0", overflow_o); end
        for (int n = 2; n <= 5; n++) begin
            check64($sformatf("full_pp_order%0d", n), nonce_o, make_nonce(4'(n)));
            nonce_ready_i = 1'b1;
            tick();
            nonce_ready_i = 1'b0;
        end
        // Push and pop together with a single entry held.
        send_nonce(4'd6);
        for (int i = 1; i <= 7; i++) send_byte({4'd7, 4'(i)});
        nonce_ready_i = 1'b1;
        send_byte(8'h78);
        nonce_ready_i = 1'b0;
        compared++;
        if (nonce_valid_o !== 1'b1) begin mismatched++; $display("[TB] FAIL one_pp_valid: got %b expected 1", nonce_valid_o); end
        compared++;
        if (count_o !== 3'd1) begin mismatched++; $display("[TB] FAIL one_pp_count: got %0d expected 1", count_o); end
        check64("one_pp_head", nonce_o, make_nonce(4'd7));
        do_flush();
    endtask

    task automatic test_flush_priority();
        logic [7:0] seq [8];
        seq = '{8'hAA, 8'hA7, 8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1};
        send_nonce(4'd9);
        for (int i = 1; i <= 3; i++) send_byte(8'(8'h30 + i));
        byte_i       = 8'h55;
        byte_valid_i = 1'b1;
        flush_i      = 1'b1;
        tick();
        byte_valid_i = 1'b0;
        flush_i      = 1'b0;
        compared++;
        if (count_o !== 3'd0) begin mismatched++; $display("[TB] FAIL flush_count: got %0d expected 0", count_o); end
        compared++;
        if (nonce_valid_o !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_valid: got %b expected 0", nonce_valid_o); end
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
        check64("flush_next_nonce", nonce_o, 64'hA1A2A3A4A5A6A7AA);
        compared++;
        if (count_o !== 3'd1) begin mismatched++; $display("[TB] FAIL flush_next_count: got %0d expected 1", count_o); end
        do_flush();
    endtask

    task automatic test_async_reset();
        send_nonce(4'd3);
        for (int i = 1; i <= 5; i++) send_byte({4'hE, 4'(i)});
        #2;
        rst_ni = 1'b0;
        #1;
        compared++;
        if (count_o !== 3'd0) begin mismatched++; $display("[TB] FAIL arst_count: got %0d expected 0", count_o); end
        compared++;
        if (nonce_valid_o !== 1'b0) begin mismatched++; $display("[TB] FAIL arst_valid: got %b expected 0", nonce_valid_o); end
        compared++;
        if (overflow_o !== 1'b0) begin mismatched++; $display("[TB] FAIL arst_overflow: got %b expected 0", overflow_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) send_byte({4'hB, 4'(i)});
        check64("arst_next_nonce", nonce_o, 64'hB8B7B6B5B4B3B2B1);
        compared++;
        if (count_o !== 3'd1) begin mismatched++; $display("[TB] FAIL arst_next_count: got %0d expected 1", count_o); end
        do_flush();
    endtask

    task automatic test_back_to_back();
        send_nonce(4'hC);
        send_nonce(4'hD);
        tick();
        check64("bp_hold_head", nonce_o, 64'hC8C7C6C5C4C3C2C1);
        nonce_ready_i = 1'b1;
        tick();
        check64("bp_second_head", nonce_o, 64'hD8D7D6D5D4D3D2D1);
        nonce_ready_i = 1'b0;
        tick();
        check64("bp_stable", nonce_o, 64'hD8D7D6D5D4D3D2D1);
        compared++;
        if (count_o !== 3'd1) begin mismatched++; $display("[TB] FAIL bp_mid_count: got %0d expected 1", count_o); end
        nonce_ready_i = 1'b1;
        tick();
        nonce_ready_i = 1'b0;
        compared++;
        if (count_o !== 3'd0) begin mismatched++; $display("[TB] FAIL bp_final_count: got %0d expected 0", count_o); end
        compared++;
        if (nonce_valid_o !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_final_valid: got %b expected 0", nonce_valid_o); end
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        rst_ni        = 1'b0;
        byte_i        = 8'h00;
        byte_valid_i  = 1'b0;
        flush_i       = 1'b0;
        nonce_ready_i = 1'b0;
        #12;
        test_reset();
        test_assembly();
        test_overflow();
        test_full_push_pop();
        test_flush_priority();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_nonce_queue
